// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked MIPS EX-stage ALU with iterative mult/div and HI/LO
// Divide support is built only when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             ovf,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     opnd;
  logic                 neg_lo;

  logic                 is_mul, is_div, sgn, a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b, sum, diff;
  logic                 add_ovf, sub_ovf, alu_ovf;
  logic [WIDTH-1:0]     alu_res, fix_hi, fix_lo;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_neg;

`ifdef ALU_SEQ_DIV_EN
  logic                 op_div, neg_hi;
  logic [WIDTH:0]       div_trial;
`endif

  assign is_mul = (ctl[3:1] == 3'b100);
`ifdef ALU_SEQ_DIV_EN
  assign is_div = (ctl[3:1] == 3'b101);
`else
  assign is_div = 1'b0;
`endif

  // Signed variants work on magnitudes; the sign is reapplied in FIX.
  assign sgn   = ~ctl[0];
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctl)
      4'b0010: begin alu_res = sum;  alu_ovf = add_ovf; end
      4'b0110: begin alu_res = diff; alu_ovf = sub_ovf; end
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b1100: alu_res = ~(a | b);
      4'b1101: alu_res = a ^ b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      4'b1110: alu_res = hi;
      4'b1111: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // prod holds {partial, multiplier} for MUL and {remainder, quotient} for DIV.
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
  assign prod_neg = -prod;
`ifdef ALU_SEQ_DIV_EN
  assign div_trial = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} - {1'b0, opnd};
`endif

  // Low half of the negated product equals the negated quotient, so fix_lo is shared.
  always_comb begin
    fix_lo = neg_lo ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0];
    fix_hi = neg_lo ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
`ifdef ALU_SEQ_DIV_EN
    if (op_div)
      fix_hi = neg_hi ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_mul)                 state_n = S_MUL;
          else if (is_div && b != '0) state_n = S_DIV;
          else                        state_n = S_DONE;
        end
      end
      S_MUL, S_DIV: if (cnt == LAST) state_n = S_FIX;
      S_FIX:        state_n = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default:      state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      prod   <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
      out    <= '0;
      hi     <= '0;
      lo     <= '0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      op_div <= 1'b0;
      neg_hi <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          cnt    <= '0;
          prod   <= {{WIDTH{1'b0}}, mag_a};
          opnd   <= mag_b;
          neg_lo <= a_neg ^ b_neg;
`ifdef ALU_SEQ_DIV_EN
          op_div <= is_div;
          neg_hi <= a_neg;
          if (is_div && b == '0) begin
            lo  <= '1;
            hi  <= a;
            out <= '1;
            ovf <= 1'b0;
            dz  <= 1'b1;
          end
`endif
          if (!is_mul && !is_div) begin
            out <= alu_res;
            ovf <= alu_ovf;
            dz  <= 1'b0;
          end
        end
        S_MUL: begin
          prod <= {mul_sum, prod[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          if (!div_trial[WIDTH])
            prod <= {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
          else
            prod <= {prod[2*WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
`endif
        S_FIX: begin
          hi  <= fix_hi;
          lo  <= fix_lo;
          out <= fix_lo;
          ovf <= 1'b0;
          dz  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign z = (out == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with a 64-bit arithmetic reference model
// Divide expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  ctl;
  logic [31:0] a, b, out, hi, lo;
  logic        z, ovf, dz;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctl(ctl), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .z(z), .ovf(ovf), .dz(dz), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] out, hi, lo;
    logic        ovf, dz;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mhi, mlo;
  logic        rdy_rand;

  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference: 64-bit integer arithmetic on the architectural rules, updating model HI/LO.
  function automatic void model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                output exp_t e, output int lat);
    longint      sx, sy, ux, uy, s;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    e.out = 32'd0;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    lat   = 1;
    case (c)
      4'b0010: begin s = sx + sy; e.out = 32'(s); e.ovf = (s > SMAX) || (s < SMIN); end
      4'b0110: begin s = sx - sy; e.out = 32'(s); e.ovf = (s > SMAX) || (s < SMIN); end
      4'b0000: e.out = x & y;
      4'b0001: e.out = x | y;
      4'b1100: e.out = ~(x | y);
      4'b1101: e.out = x ^ y;
      4'b0111: e.out = (sx < sy) ? 32'd1 : 32'd0;
      4'b1110: e.out = mhi;
      4'b1111: e.out = mlo;
      4'b1000, 4'b1001: begin
        p = (c == 4'b1000) ? 64'(sx * sy) : 64'(ux * uy);
        mhi = p[63:32];
        mlo = p[31:0];
        e.out = mlo;
        lat = 34;
      end
`ifdef ALU_SEQ_DIV_EN
      4'b1010, 4'b1011: begin
        if (y == 32'd0) begin
          mlo = 32'hFFFFFFFF;
          mhi = x;
          e.dz = 1'b1;
        end else begin
          mlo = (c == 4'b1010) ? 32'(sx / sy) : 32'(ux / uy);
          mhi = (c == 4'b1010) ? 32'(sx % sy) : 32'(ux % uy);
          lat = 34;
        end
        e.out = mlo;
      end
`endif
      default: e.out = 32'd0;
    endcase
    e.hi = mhi;
    e.lo = mlo;
  endfunction

  task automatic do_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    int   n, lat;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", in_ready, 1'b1);
      return;
    end
    model(c, x, y, e, lat);
    sb.push_back(e);
    in_valid = 1'b1;
    ctl = c;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctl = 4'($urandom);
    a = $urandom;
    b = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk($sformatf("latency_ctl%b", c), 64'(n), 64'(lat));
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got out %h expected none", out);
        end else begin
          mon_e = sb.pop_front();
          chk("out", out, mon_e.out);
          chk("z", z, mon_e.out == 32'd0);
          chk("ovf", ovf, mon_e.ovf);
          chk("dz", dz, mon_e.dz);
          chk("hi", hi, mon_e.hi);
          chk("lo", lo, mon_e.lo);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ctl = 4'd0; a = 32'd0; b = 32'd0;
    out_ready = 1'b1; rdy_rand = 1'b1; mhi = 32'd0; mlo = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_out", out, 32'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_z", z, 1'b1);
    chk("rst_ovf_dz", {ovf, dz}, 2'b00);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    do_op(4'b0010, 32'h7FFFFFFF, 32'd1);
    chk("add_max_out", out, 32'h80000000);
    chk("add_max_ovf", ovf, 1'b1);
    do_op(4'b0111, 32'h80000000, 32'd1);
    chk("slt_min_out", out, 32'd1);
    do_op(4'b0110, 32'd5, 32'd5);
    chk("sub_eq_z", z, 1'b1);
    do_op(4'b1000, 32'hFFFFFFFD, 32'd7);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    do_op(4'b1110, 32'd0, 32'd0);
    chk("mfhi_out", out, 32'hFFFFFFFF);
`ifdef ALU_SEQ_DIV_EN
    do_op(4'b1010, 32'hFFFFFFF9, 32'd2);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    do_op(4'b1010, 32'd9, 32'd0);
    chk("div0_dz", dz, 1'b1);
    chk("div0_hilo", {hi, lo}, {32'd9, 32'hFFFFFFFF});
    do_op(4'b1011, 32'd100, 32'd7);
    chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    do_op(4'b1010, 32'h80000000, 32'hFFFFFFFF);
    chk("div_min_hilo", {hi, lo}, {32'd0, 32'h80000000});
    chk("div_min_dz", dz, 1'b0);
`else
    do_op(4'b1010, 32'd100, 32'd7);
    chk("div_off_out", out, 32'd0);
    chk("div_off_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
`endif

    @(posedge clk);
    #2;
    rdy_rand = 1'b0;
    out_ready = 1'b0;
    do_op(4'b0010, 32'd5, 32'd7);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      ctl = 4'($urandom);
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_out", out, 32'd12);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    rdy_rand = 1'b1;

    do_op(4'b0010, 32'd1, 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    ctl = 4'b1000;
    a = $urandom;
    b = $urandom;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_hilo", {out, hi, lo}, 96'd0);
    chk("midrst_flags", {out_valid, ovf, dz, z}, 4'b0001);
    sb.delete();
    mhi = 32'd0;
    mlo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1'b1);
    do_op(4'b1110, 32'd0, 32'd0);
    do_op(4'b0010, 32'd3, 32'd4);

    for (int i = 0; i < 300; i++)
      do_op(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());

    @(posedge clk);
    #2;
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
